// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative RV64M multiply/divide unit for the execute stage.
// Define EXECUTE_MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle one.
module execute_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        muldiv_i_valid,
  input  logic [12:0] muldiv_i_op,
  input  logic [63:0] muldiv_i_src1,
  input  logic [63:0] muldiv_i_src2,
  input  logic        muldiv_i_flush,
  output logic        muldiv_o_ready,
  output logic        muldiv_o_busy,
  output logic        muldiv_o_valid,
  output logic [63:0] muldiv_o_result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  typedef enum logic [3:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
    OP_DIV, OP_DIVU, OP_REM, OP_REMU,
    OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW
  } op_e;

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  function automatic logic [63:0] mul_select(input op_e op, input logic [127:0] p);
    logic [63:0] r;
    case (op)
      OP_MUL:  r = p[63:0];
      OP_MULW: r = sext32(p[31:0]);
      default: r = p[127:64];
    endcase
    return r;
  endfunction

  function automatic logic [63:0] div_select(input op_e op, input logic [63:0] q,
                                             input logic [63:0] r);
    logic [63:0] v;
    case (op)
      OP_DIV, OP_DIVU:   v = q;
      OP_REM, OP_REMU:   v = r;
      OP_DIVW, OP_DIVUW: v = sext32(q[31:0]);
      default:           v = sext32(r[31:0]);
    endcase
    return v;
  endfunction

  state_e      state, state_n;
  logic [6:0]  cnt;
  logic [63:0] acc, lo, opd, result_q;
  op_e         op_q;
  logic        mul_q, w_q, neg_q, neg_r;

  // Request decode; the highest set op bit wins.
  op_e         dec_op;
  logic        dec_w, dec_mul, dec_sa, dec_sb, dec_sdiv;
  logic [63:0] a_f, b_f, a_mag, b_mag;
  logic        a_neg, b_neg, div_zero, div_ovf, direct, accept;
  logic [63:0] direct_result;
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
  logic [127:0] fast_prod;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_op = OP_REMUW;
    if      (muldiv_i_op[12]) dec_op = OP_MUL;
    else if (muldiv_i_op[11]) dec_op = OP_MULH;
    else if (muldiv_i_op[10]) dec_op = OP_MULHSU;
    else if (muldiv_i_op[9])  dec_op = OP_MULHU;
    else if (muldiv_i_op[8])  dec_op = OP_DIV;
    else if (muldiv_i_op[7])  dec_op = OP_DIVU;
    else if (muldiv_i_op[6])  dec_op = OP_REM;
    else if (muldiv_i_op[5])  dec_op = OP_REMU;
    else if (muldiv_i_op[4])  dec_op = OP_MULW;
    else if (muldiv_i_op[3])  dec_op = OP_DIVW;
    else if (muldiv_i_op[2])  dec_op = OP_DIVUW;
    else if (muldiv_i_op[1])  dec_op = OP_REMW;

    dec_w    = dec_op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
    dec_mul  = dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW};
    dec_sa   = !(dec_op inside {OP_MULHU, OP_DIVU, OP_REMU, OP_DIVUW, OP_REMUW});
    dec_sb   = dec_sa && (dec_op != OP_MULHSU);
    dec_sdiv = dec_sa && !dec_mul;

    if (dec_w) begin
      a_f = dec_sa ? sext32(muldiv_i_src1[31:0]) : {32'd0, muldiv_i_src1[31:0]};
      b_f = dec_sb ? sext32(muldiv_i_src2[31:0]) : {32'd0, muldiv_i_src2[31:0]};
    end else begin
      a_f = muldiv_i_src1;
      b_f = muldiv_i_src2;
    end
    a_neg = dec_sa && a_f[63];
    b_neg = dec_sb && b_f[63];
    a_mag = a_neg ? -a_f : a_f;
    b_mag = b_neg ? -b_f : b_f;

    // Divide special cases skip the iteration entirely.
    div_zero = !dec_mul && (b_f == 64'd0);
    div_ovf  = dec_sdiv && (b_f == '1) &&
               (dec_w ? (a_f[31:0] == 32'h8000_0000) : (a_f == 64'h8000_0000_0000_0000));
    direct        = div_zero || div_ovf;
    direct_result = div_select(dec_op, div_zero ? '1 : a_f, div_zero ? a_f : 64'd0);
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
    fast_prod = {64'd0, a_mag} * {64'd0, b_mag};
    if (a_neg ^ b_neg) fast_prod = -fast_prod;
    if (dec_mul) begin
      direct        = 1'b1;
      direct_result = mul_select(dec_op, fast_prod);
    end
`endif
    accept = muldiv_i_valid && (state == S_IDLE) && (muldiv_i_op != 13'd0) && !muldiv_i_flush;
  end

  // One iteration step: multiply is {acc,lo} shift-right-add, divide is restoring shift-left.
  logic [64:0]  shifted, mul_sum;
  logic         div_ge;
  logic [63:0]  acc_n, lo_n, quo, rem;
  logic [127:0] prod_mag, prod;
  logic [63:0]  final_result;

  always_comb begin
    shifted = {acc, lo[63]};
    div_ge  = shifted >= {1'b0, opd};
    mul_sum = {1'b0, acc} + {1'b0, (lo[0] ? opd : 64'd0)};
    if (mul_q) begin
      acc_n = mul_sum[64:1];
      lo_n  = {mul_sum[0], lo[63:1]};
    end else begin
      acc_n = div_ge ? (shifted[63:0] - opd) : shifted[63:0];
      lo_n  = {lo[62:0], div_ge};
    end
    // A 32-step multiply leaves its 64-bit product in {acc,lo}[95:32].
    prod_mag = w_q ? {64'd0, acc_n[31:0], lo_n[63:32]} : {acc_n, lo_n};
    prod     = neg_q ? -prod_mag : prod_mag;
    quo      = neg_q ? -lo_n : lo_n;
    rem      = neg_r ? -acc_n : acc_n;
    final_result = mul_q ? mul_select(op_q, prod) : div_select(op_q, quo, rem);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n        = state;
    muldiv_o_ready = 1'b0;
    muldiv_o_busy  = 1'b0;
    muldiv_o_valid = 1'b0;
    case (state)
      S_IDLE: begin
        muldiv_o_ready = 1'b1;
        if (accept) state_n = direct ? S_DONE : S_CALC;
      end
      S_CALC: begin
        muldiv_o_busy = 1'b1;
        if (muldiv_i_flush)   state_n = S_IDLE;
        else if (cnt == 7'd1) state_n = S_DONE;
      end
      S_DONE: begin
        muldiv_o_busy  = 1'b1;
        muldiv_o_valid = 1'b1;
        state_n        = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      lo       <= '0;
      opd      <= '0;
      result_q <= '0;
      op_q     <= OP_MUL;
      mul_q    <= 1'b0;
      w_q      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else if (state == S_IDLE) begin
      if (accept) begin
        op_q  <= dec_op;
        mul_q <= dec_mul;
        w_q   <= dec_w;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        cnt   <= dec_w ? 7'd32 : 7'd64;
        acc   <= '0;
        if (dec_mul) begin
          opd <= a_mag;
          lo  <= b_mag;
        end else begin
          opd <= b_mag;
          lo  <= dec_w ? {a_mag[31:0], 32'd0} : a_mag;
        end
        if (direct) result_q <= direct_result;
      end
    end else if (state == S_CALC && !muldiv_i_flush) begin
      acc <= acc_n;
      lo  <= lo_n;
      cnt <= cnt - 7'd1;
      if (cnt == 7'd1) result_q <= final_result;
    end
  end

  assign muldiv_o_result = result_q;

endmodule

// File: tb/tb_execute_muldiv.sv
// Self-checking bench for execute_muldiv: directed corner cases plus randomized ops
// compared against a plain-arithmetic RV64M reference model.
module tb_execute_muldiv;
  logic        clk = 1'b0;
  logic        rst, valid, flush;
  logic [12:0] op;
  logic [63:0] src1, src2;
  logic        ready, busy, o_valid;
  logic [63:0] result;
  int total = 0;
  int bad = 0;

  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  execute_muldiv dut (
    .clk(clk), .rst(rst),
    .muldiv_i_valid(valid), .muldiv_i_op(op),
    .muldiv_i_src1(src1), .muldiv_i_src2(src2), .muldiv_i_flush(flush),
    .muldiv_o_ready(ready), .muldiv_o_busy(busy),
    .muldiv_o_valid(o_valid), .muldiv_o_result(result)
  );

  function automatic logic [63:0] sx32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference: RISC-V M semantics from plain arithmetic, keyed by op bit number.
  function automatic logic [63:0] model(input int bit_no, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [31:0]  a32, b32, t32;
    longint       sa, sb;
    int           sa32, sb32;
    logic [63:0]  r;
    a32 = a[31:0]; b32 = b[31:0];
    sa = a; sb = b; sa32 = a32; sb32 = b32;
    r = '0; t32 = '0;
    case (bit_no)
      12: r = a * b;
      11: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; r = p[127:64]; end
      10: begin p = {{64{a[63]}}, a} * {64'd0, b};       r = p[127:64]; end
      9:  begin p = {64'd0, a} * {64'd0, b};             r = p[127:64]; end
      8:  if (b == 0) r = ONES; else if (a == MIN64 && b == ONES) r = a; else r = sa / sb;
      7:  if (b == 0) r = ONES; else r = a / b;
      6:  if (b == 0) r = a; else if (a == MIN64 && b == ONES) r = 0; else r = sa % sb;
      5:  if (b == 0) r = a; else r = a % b;
      4:  begin t32 = a32 * b32; r = sx32(t32); end
      3:  if (b32 == 0) r = ONES;
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r = sx32(a32);
          else begin t32 = sa32 / sb32; r = sx32(t32); end
      2:  if (b32 == 0) r = ONES; else begin t32 = a32 / b32; r = sx32(t32); end
      1:  if (b32 == 0) r = sx32(a32);
          else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r = 0;
          else begin t32 = sa32 % sb32; r = sx32(t32); end
      default: if (b32 == 0) r = sx32(a32); else begin t32 = a32 % b32; r = sx32(t32); end
    endcase
    return r;
  endfunction

  // Expected cycle of the result strobe, counting the accept cycle as 0.
  function automatic int exp_lat(input int bit_no, input logic [63:0] a, input logic [63:0] b);
    bit is_w, is_mul, sgn, zero, ovf;
    is_w   = bit_no <= 4;
    is_mul = bit_no >= 9 || bit_no == 4;
    sgn    = bit_no inside {8, 6, 3, 1};
    zero   = is_w ? (b[31:0] == 32'd0) : (b == 64'd0);
    ovf    = sgn && (is_w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                          : (a == MIN64 && b == ONES));
    if (!is_mul && (zero || ovf)) return 1;
`ifdef EXECUTE_MULDIV_FAST_MUL_EN
    if (is_mul) return 1;
`endif
    return is_w ? 33 : 65;
  endfunction

  // Called just after a rising edge with the DUT idle; leaves just after the edge following DONE.
  task automatic run_op(input int bit_no, input logic [12:0] extra, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] res, output int lat,
                        output bit prof_ok);
    prof_ok = 1'b1; lat = 0; res = '0;
    valid = 1'b1; op = (13'd1 << bit_no) | extra; src1 = a; src2 = b;
    @(posedge clk); #1;
    valid = 1'b0; op = '0;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (busy !== 1'b1 || ready !== 1'b0) prof_ok = 1'b0;
      if (o_valid === 1'b1) begin
        lat = c;
        res = result;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (busy !== 1'b0 || ready !== 1'b1 || o_valid !== 1'b0) prof_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; flush = 1'b0; op = '0; src1 = '0; src2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (ready !== 1'b1)   begin bad++; $display("FAIL reset ready: got %b want 1", ready); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset valid: got %b want 0", o_valid); end
    total++; if (result !== 64'd0) begin bad++; $display("FAIL reset result: got %h want 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_div_special();
    logic [63:0] res; int lat; bit ok;
    run_op(8, 0, 64'd100, 64'd0, res, lat, ok);
    total++; if (res !== ONES) begin bad++; $display("FAIL div_by_zero: got %h want %h", res, ONES); end
    total++; if (lat !== 1)    begin bad++; $display("FAIL div_by_zero latency: got %0d want 1", lat); end
    total++; if (!ok)          begin bad++; $display("FAIL div_by_zero busy/ready profile"); end
    run_op(6, 0, 64'd100, 64'd0, res, lat, ok);
    total++; if (res !== 64'd100) begin bad++; $display("FAIL rem_by_zero: got %h want %h", res, 64'd100); end
    run_op(8, 0, MIN64, ONES, res, lat, ok);
    total++; if (res !== MIN64) begin bad++; $display("FAIL div_overflow: got %h want %h", res, MIN64); end
    total++; if (lat !== 1)     begin bad++; $display("FAIL div_overflow latency: got %0d want 1", lat); end
    run_op(6, 0, MIN64, ONES, res, lat, ok);
    total++; if (res !== 64'd0) begin bad++; $display("FAIL rem_overflow: got %h want 0", res); end
    total++; if (lat !== 1)     begin bad++; $display("FAIL rem_overflow latency: got %0d want 1", lat); end
    run_op(3, 0, 64'h1234_5678_8000_0000, 64'h0000_0000_FFFF_FFFF, res, lat, ok);
    total++; if (res !== 64'hFFFF_FFFF_8000_0000 || lat !== 1)
      begin bad++; $display("FAIL divw_overflow: got %h lat %0d want ffffffff80000000 lat 1", res, lat); end
    run_op(2, 0, 64'h5, 64'hFFFF_FFFF_0000_0000, res, lat, ok);
    total++; if (res !== ONES || lat !== 1)
      begin bad++; $display("FAIL divuw_by_zero: got %h lat %0d want all-ones lat 1", res, lat); end
  endtask

  task automatic test_signed_divide();
    logic [63:0] res; int lat; bit ok;
    run_op(8, 0, -64'sd7, 64'd2, res, lat, ok);
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_neg7_2: got %h want fffffffffffffffd", res); end
    run_op(6, 0, -64'sd7, 64'd2, res, lat, ok);
    total++; if (res !== ONES) begin bad++; $display("FAIL rem_neg7_2: got %h want %h", res, ONES); end
    run_op(7, 0, 64'd7, 64'd2, res, lat, ok);
    total++; if (res !== 64'd3) begin bad++; $display("FAIL divu_7_2: got %h want 3", res); end
    total++; if (lat !== 65)    begin bad++; $display("FAIL divu latency: got %0d want 65", lat); end
    total++; if (!ok)           begin bad++; $display("FAIL divu busy/ready profile"); end
  endtask

  task automatic test_w_ops();
    logic [63:0] res; int lat; bit ok;
    run_op(4, 0, 64'h7FFF_FFFF, 64'd2, res, lat, ok);
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL mulw: got %h want fffffffffffffffe", res); end
    total++; if (lat !== exp_lat(4, 64'h7FFF_FFFF, 64'd2))
      begin bad++; $display("FAIL mulw latency: got %0d want %0d", lat, exp_lat(4, 64'h7FFF_FFFF, 64'd2)); end
    run_op(2, 0, 64'hFFFF_FFFF, 64'd1, res, lat, ok);
    total++; if (res !== ONES) begin bad++; $display("FAIL divuw: got %h want %h", res, ONES); end
    total++; if (lat !== 33)   begin bad++; $display("FAIL divuw latency: got %0d want 33", lat); end
    total++; if (!ok)          begin bad++; $display("FAIL divuw busy/ready profile"); end
  endtask

  task automatic test_mul_high();
    logic [63:0] res; int lat; bit ok;
    run_op(11, 0, ONES, ONES, res, lat, ok);
    total++; if (res !== 64'd0) begin bad++; $display("FAIL mulh: got %h want 0", res); end
    run_op(9, 0, ONES, 64'd2, res, lat, ok);
    total++; if (res !== 64'd1) begin bad++; $display("FAIL mulhu: got %h want 1", res); end
    run_op(10, 0, ONES, 64'd2, res, lat, ok);
    total++; if (res !== ONES)  begin bad++; $display("FAIL mulhsu: got %h want %h", res, ONES); end
    total++; if (lat !== exp_lat(10, ONES, 64'd2))
      begin bad++; $display("FAIL mulhsu latency: got %0d want %0d", lat, exp_lat(10, ONES, 64'd2)); end
  endtask

  task automatic test_priority();
    logic [63:0] res; int lat; bit ok; bit seen;
    run_op(12, 13'h020, 64'd6, 64'd7, res, lat, ok);
    total++; if (res !== 64'd42) begin bad++; $display("FAIL multihot mul: got %h want 42", res); end
    run_op(8, 13'h001, 64'd100, 64'd7, res, lat, ok);
    total++; if (res !== 64'd14) begin bad++; $display("FAIL multihot div: got %h want 14", res); end
    valid = 1'b1; op = '0; src1 = 64'd1; src2 = 64'd0;
    @(posedge clk); #1;
    valid = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0)
      begin bad++; $display("FAIL op_zero ignored: ready %b busy %b want 1 0", ready, busy); end
    seen = 1'b0;
    repeat (3) begin @(negedge clk); if (o_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL op_zero strobe: got strobe want none"); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    logic [63:0] prev; int lat; bit ok; bit seen;
    run_op(7, 0, 64'd7, 64'd2, prev, lat, ok);
    valid = 1'b1; op = 13'h100; src1 = 64'd1_000_000; src2 = 64'd7;
    @(posedge clk); #1;
    valid = 1'b0; op = '0;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    total++; if (ready !== 1'b1)   begin bad++; $display("FAIL flush ready: got %b want 1", ready); end
    total++; if (busy !== 1'b0)    begin bad++; $display("FAIL flush busy: got %b want 0", busy); end
    total++; if (result !== 64'd3) begin bad++; $display("FAIL flush result kept: got %h want 3", result); end
    seen = 1'b0;
    repeat (80) begin @(negedge clk); if (o_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush strobe: got strobe want none"); end
    @(posedge clk); #1;
    valid = 1'b1; op = 13'h100; src1 = 64'd100; src2 = 64'd0; flush = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; op = '0; flush = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0)
      begin bad++; $display("FAIL idle flush blocks accept: ready %b busy %b valid %b want 1 0 0", ready, busy, o_valid); end
    @(posedge clk); #1;
    valid = 1'b1; op = 13'h100; src1 = 64'd100; src2 = 64'd0;
    @(posedge clk); #1;
    valid = 1'b0; op = '0; flush = 1'b1;
    total++; if (o_valid !== 1'b1 || result !== ONES)
      begin bad++; $display("FAIL done flush strobe: valid %b result %h want 1 %h", o_valid, result, ONES); end
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] res; int lat; bit ok;
    valid = 1'b1; op = 13'h080; src1 = 64'd7; src2 = 64'd2;
    @(posedge clk); #1;
    valid = 1'b0; op = '0;
    repeat (19) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL busy before reset: got %b want 1", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (ready !== 1'b1 || busy !== 1'b0 || o_valid !== 1'b0 || result !== 64'd0)
      begin bad++; $display("FAIL mid reset outputs: ready %b busy %b valid %b result %h want 1 0 0 0", ready, busy, o_valid, result); end
    run_op(6, 0, -64'sd7, 64'd2, res, lat, ok);
    total++; if (res !== ONES || lat !== 65 || !ok)
      begin bad++; $display("FAIL op after reset: got %h lat %0d want %h lat 65", res, lat, ONES); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2; int l1, l2; bit ok1, ok2;
    run_op(12, 0, 64'd3, 64'd5, r1, l1, ok1);
    run_op(5, 0, 64'd100, 64'd7, r2, l2, ok2);
    total++; if (r1 !== 64'd15 || r2 !== 64'd2)
      begin bad++; $display("FAIL back_to_back results: got %h %h want f 2", r1, r2); end
    total++; if (l2 !== 65 || !ok1 || !ok2)
      begin bad++; $display("FAIL back_to_back timing: second lat %0d want 65", l2); end
  endtask

  function automatic logic [63:0] pick();
    logic [63:0] v;
    case ($urandom_range(0, 6))
      0:       v = 64'd0;
      1:       v = ONES;
      2:       v = MIN64;
      3:       v = 64'($urandom_range(0, 20));
      4:       v = 64'hFFFF_FFFF_8000_0000;
      5:       v = {32'd0, $urandom};
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  task automatic test_random();
    logic [63:0] a, b, res, want; logic [12:0] extra; int bit_no, lat; bit ok;
    for (int i = 0; i < 60; i++) begin
      bit_no = $urandom_range(0, 12);
      a = pick(); b = pick();
      extra = ($urandom_range(0, 3) == 0) ? (13'($urandom) & ((13'd1 << bit_no) - 13'd1)) : 13'd0;
      run_op(bit_no, extra, a, b, res, lat, ok);
      want = model(bit_no, a, b);
      total++; if (res !== want)
        begin bad++; $display("FAIL random op bit %0d a=%h b=%h: got %h want %h", bit_no, a, b, res, want); end
      total++; if (lat !== exp_lat(bit_no, a, b))
        begin bad++; $display("FAIL random latency bit %0d: got %0d want %0d", bit_no, lat, exp_lat(bit_no, a, b)); end
      total++; if (!ok) begin bad++; $display("FAIL random busy/ready profile bit %0d", bit_no); end
    end
  endtask

  initial begin
    test_reset();
    test_div_special();
    test_signed_divide();
    test_w_ops();
    test_mul_high();
    test_priority();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
